bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_to_bin_mul10_add.sv | 23 ++
 rtl/bcd_to_bin.sv | 138 +++++++++++++
 tb/tb_bcd_to_bin.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared definitions for the BCD-to-binary entry block.
//   BIN_W   : width of the binary accumulator and result
//   BCD_MAX : largest legal BCD digit value
//   MAX_VAL : largest value reachable with four digits
//   state_t : entry FSM states
//   is_bcd  : true when a 4-bit nibble is a legal decimal digit
package bcd_pkg;

  localparam int BIN_W   = 16;
  localparam int BCD_MAX = 9;
  localparam int MAX_VAL = 9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no digits entered
    ST_ENTRY = 2'd1,  // some digits, room for more
    ST_FULL  = 2'd2,  // digit budget exhausted
    ST_DONE  = 2'd3   // result just published, accumulator empty
  } state_t;

  function automatic logic is_bcd(input logic [3:0] d);
    is_bcd = (d <= 4'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_to_bin_mul10_add.sv
// mul10_add -- combinational acc*10 + digit.
//   acc    : 16-bit running binary value
//   digit  : 4-bit decimal digit to append
//   result : 16-bit acc*10 + digit
// The multiply is built from two shifts so no multiplier is inferred.
module mul10_add
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] result
);

  logic [BIN_W-1:0] times8_s;
  logic [BIN_W-1:0] times2_s;
  logic [BIN_W-1:0] digit_ext_s;

  assign times8_s    = acc << 3;
  assign times2_s    = acc << 1;
  assign digit_ext_s = {{(BIN_W-4){1'b0}}, digit};
  assign result      = times8_s + times2_s + digit_ext_s;

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin -- accumulates decimal digits into a binary value.
//   clk, rst     : clock and synchronous active-high reset
//   digit_valid  : strobe offering 'digit'
//   digit        : BCD digit (10..15 are rejected)
//   commit       : publish accumulator to bin_out and restart
//   clear        : discard the entry in progress (beats commit/digit)
//   acc_out      : live value of digits entered so far
//   bin_out      : last committed value
//   result_valid : one-cycle pulse after a commit
//   digit_count  : digits currently held in acc_out
//   full         : digit_count has reached MAX_DIGITS
//   err          : one-cycle pulse after a rejected digit
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int MAX_DIGITS = 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             commit,
  input  logic             clear,
  output logic [BIN_W-1:0] acc_out,
  output logic [BIN_W-1:0] bin_out,
  output logic             result_valid,
  output logic [2:0]       digit_count,
  output logic             full,
  output logic             err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t           state_r, state_s;
  logic [BIN_W-1:0] acc_r, acc_s;
  logic [BIN_W-1:0] bin_r, bin_s;
  logic [2:0]       count_r, count_s;
  logic             rv_r, rv_s;
  logic             err_r, err_s;
  logic             full_r, full_s;

  logic             can_accept_s;
  logic             digit_ok_s;
  logic             digit_rej_s;
  logic [2:0]       count_inc_s;
  logic [BIN_W-1:0] mac_s;

  // In DONE the accumulator is already zero, so acc*10+digit starts a new number.
  mul10_add u_mul10_add (
    .acc    (acc_r),
    .digit  (digit),
    .result (mac_s)
  );

  assign count_inc_s = count_r + 3'd1;
  assign digit_ok_s  = digit_valid & is_bcd(digit) & can_accept_s;
  assign digit_rej_s = digit_valid & ~digit_ok_s;
  assign full_s      = (count_s == MAX_CNT);

  // Decide whether the current state still has room for a digit.
  always_comb begin
    can_accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_ENTRY, ST_DONE: can_accept_s = 1'b1;
      ST_FULL:                    can_accept_s = 1'b0;
      default:                    can_accept_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic; clear outranks commit, commit outranks digit-only.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    bin_s   = bin_r;
    count_s = count_r;
    rv_s    = 1'b0;
    err_s   = 1'b0;
    if (clear) begin
      state_s = ST_IDLE;
      acc_s   = {BIN_W{1'b0}};
      count_s = 3'd0;
    end else if (commit) begin
      // A digit arriving with commit is folded in before publishing.
      if (digit_ok_s) begin
        bin_s = mac_s;
      end else begin
        bin_s = acc_r;
      end
      rv_s    = 1'b1;
      err_s   = digit_rej_s;
      state_s = ST_DONE;
      acc_s   = {BIN_W{1'b0}};
      count_s = 3'd0;
    end else if (digit_ok_s) begin
      acc_s   = mac_s;
      count_s = count_inc_s;
      if (count_inc_s == MAX_CNT) begin
        state_s = ST_FULL;
      end else begin
        state_s = ST_ENTRY;
      end
    end else if (digit_rej_s) begin
      err_s = 1'b1;
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      acc_r   <= {BIN_W{1'b0}};
      bin_r   <= {BIN_W{1'b0}};
      count_r <= 3'd0;
      rv_r    <= 1'b0;
      err_r   <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      bin_r   <= bin_s;
      count_r <= count_s;
      rv_r    <= rv_s;
      err_r   <= err_s;
      full_r  <= full_s;
    end
  end

  assign acc_out      = acc_r;
  assign bin_out      = bin_r;
  assign result_valid = rv_r;
  assign digit_count  = count_r;
  assign full         = full_r;
  assign err          = err_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin -- scoreboard bench for bcd_to_bin.
// Unit 0 uses MAX_DIGITS=4, unit 1 uses MAX_DIGITS=2. Every stimulus cycle
// drives both units, models both at the arithmetic level and queues the
// expected outputs; a monitor compares one cycle later. Committed values
// are also queued separately and checked whenever result_valid rises.
module tb_bcd_to_bin;

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] bin;
    logic [2:0]  cnt;
    logic        full;
    logic        rv;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, dv0 = 1'b0, cm0 = 1'b0, cl0 = 1'b0;
  logic [3:0]  d0 = 4'd0;
  logic [15:0] acc0, bin0;
  logic [2:0]  cnt0;
  logic        rv0, full0, err0;

  logic        rst1 = 1'b1, dv1 = 1'b0, cm1 = 1'b0, cl1 = 1'b0;
  logic [3:0]  d1 = 4'd0;
  logic [15:0] acc1, bin1;
  logic [2:0]  cnt1;
  logic        rv1, full1, err1;

  bcd_to_bin #(.MAX_DIGITS(4)) dut0 (
    .clk(clk), .rst(rst0), .digit_valid(dv0), .digit(d0), .commit(cm0), .clear(cl0),
    .acc_out(acc0), .bin_out(bin0), .result_valid(rv0), .digit_count(cnt0),
    .full(full0), .err(err0)
  );

  bcd_to_bin #(.MAX_DIGITS(2)) dut1 (
    .clk(clk), .rst(rst1), .digit_valid(dv1), .digit(d1), .commit(cm1), .clear(cl1),
    .acc_out(acc1), .bin_out(bin1), .result_valid(rv1), .digit_count(cnt1),
    .full(full1), .err(err1)
  );

  int tests = 0;
  int fails = 0;

  exp_t q0[$], q1[$];
  int   rq0[$], rq1[$];

  // Reference model: plain decimal arithmetic per unit.
  int m_acc[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int m_bin[2] = '{0, 0};
  int maxd[2]  = '{4, 2};

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model(input int u, input logic r, input logic dv, input logic [3:0] d,
                       input logic cm, input logic cl, output exp_t e);
    int  newacc;
    bit  legal, rej, rv;
    legal = 1'b0; rej = 1'b0; rv = 1'b0;
    if (r) begin
      m_acc[u] = 0; m_cnt[u] = 0; m_bin[u] = 0;
    end else if (cl) begin
      m_acc[u] = 0; m_cnt[u] = 0;
    end else begin
      legal  = dv && (d <= 4'd9) && (m_cnt[u] < maxd[u]);
      rej    = dv && !legal;
      newacc = legal ? m_acc[u] * 10 + int'(d) : m_acc[u];
      if (cm) begin
        m_bin[u] = newacc; m_acc[u] = 0; m_cnt[u] = 0; rv = 1'b1;
        if (u == 0) rq0.push_back(newacc); else rq1.push_back(newacc);
      end else begin
        m_acc[u] = newacc;
        m_cnt[u] = m_cnt[u] + (legal ? 1 : 0);
      end
    end
    e.acc  = 16'(m_acc[u]);
    e.bin  = 16'(m_bin[u]);
    e.cnt  = 3'(m_cnt[u]);
    e.full = (m_cnt[u] == maxd[u]);
    e.rv   = rv;
    e.err  = rej;
  endtask

  // One cycle: unit u gets the given stimulus, the other unit idles.
  task automatic step(input int u, input logic r, input logic dv, input logic [3:0] d,
                      input logic cm, input logic cl);
    exp_t e0, e1;
    @(negedge clk);
    if (u == 0) begin
      rst0 = r; dv0 = dv; d0 = d; cm0 = cm; cl0 = cl;
      rst1 = 1'b0; dv1 = 1'b0; d1 = 4'd0; cm1 = 1'b0; cl1 = 1'b0;
      model(0, r, dv, d, cm, cl, e0);
      model(1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, e1);
    end else begin
      rst1 = r; dv1 = dv; d1 = d; cm1 = cm; cl1 = cl;
      rst0 = 1'b0; dv0 = 1'b0; d0 = 4'd0; cm0 = 1'b0; cl0 = 1'b0;
      model(1, r, dv, d, cm, cl, e1);
      model(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, e0);
    end
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic dig(input int u, input logic [3:0] d);
    step(u, 1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic cmt(input int u);
    step(u, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic reset_all();
    exp_t e0, e1;
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;
    dv0 = 1'b0; cm0 = 1'b0; cl0 = 1'b0; dv1 = 1'b0; cm1 = 1'b0; cl1 = 1'b0;
    model(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, e0);
    model(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Wait until the most recent step has been clocked in, then look at outputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  exp_t me, ma;

  // Monitor: pop one expectation per unit per stimulus cycle, and check published results.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      me = q0.pop_front();
      ma = {acc0, bin0, cnt0, full0, rv0, err0};
      tests++;
      if (ma !== me) begin
        fails++;
        $display("FAIL u0_outputs: got acc=%0d bin=%0d cnt=%0d full=%b rv=%b err=%b expected acc=%0d bin=%0d cnt=%0d full=%b rv=%b err=%b",
                 ma.acc, ma.bin, ma.cnt, ma.full, ma.rv, ma.err, me.acc, me.bin, me.cnt, me.full, me.rv, me.err);
      end
    end
    if (q1.size() > 0) begin
      me = q1.pop_front();
      ma = {acc1, bin1, cnt1, full1, rv1, err1};
      tests++;
      if (ma !== me) begin
        fails++;
        $display("FAIL u1_outputs: got acc=%0d bin=%0d cnt=%0d full=%b rv=%b err=%b expected acc=%0d bin=%0d cnt=%0d full=%b rv=%b err=%b",
                 ma.acc, ma.bin, ma.cnt, ma.full, ma.rv, ma.err, me.acc, me.bin, me.cnt, me.full, me.rv, me.err);
      end
    end
    if (rv0 === 1'b1) begin
      if (rq0.size() == 0) chk("u0_unexpected_result", 1, 0);
      else chk("u0_result", int'(bin0), rq0.pop_front());
    end
    if (rv1 === 1'b1) begin
      if (rq1.size() == 0) chk("u1_unexpected_result", 1, 0);
      else chk("u1_result", int'(bin1), rq1.pop_front());
    end
  end

  initial begin
    reset_all();
    reset_all();

    // Test 1: 1,2,3,4 then commit.
    dig(0, 4'd1); dig(0, 4'd2); dig(0, 4'd3); dig(0, 4'd4);
    settle();
    chk("t1_acc", int'(acc0), 1234);
    chk("t1_full", int'(full0), 1);
    cmt(0);
    settle();
    chk("t1_bin", int'(bin0), 1234);
    chk("t1_rv", int'(rv0), 1);
    chk("t1_cnt", int'(cnt0), 0);

    // Test 2: full at 9999, extra digit rejected, commit publishes 9999.
    dig(0, 4'd9); dig(0, 4'd9); dig(0, 4'd9); dig(0, 4'd9);
    dig(0, 4'd7);
    settle();
    chk("t2_err", int'(err0), 1);
    chk("t2_acc", int'(acc0), 9999);
    cmt(0);
    settle();
    chk("t2_bin", int'(bin0), 9999);

    // Test 3: illegal nibble after 5, then 0.
    dig(0, 4'd5); dig(0, 4'hB);
    settle();
    chk("t3_err", int'(err0), 1);
    chk("t3_acc", int'(acc0), 5);
    dig(0, 4'd0);
    settle();
    chk("t3_acc50", int'(acc0), 50);

    // Test 4: commit with digit, then clear beats commit.
    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    dig(0, 4'd4); dig(0, 4'd2);
    step(0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
    settle();
    chk("t4_bin", int'(bin0), 427);
    dig(0, 4'd1);
    step(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    settle();
    chk("t4_clr_bin", int'(bin0), 427);
    chk("t4_clr_rv", int'(rv0), 0);
    chk("t4_clr_acc", int'(acc0), 0);

    // Test 5: new number straight after a commit, then commit in IDLE.
    dig(0, 4'd8); dig(0, 4'd8); cmt(0);
    dig(0, 4'd3);
    settle();
    chk("t5_acc", int'(acc0), 3);
    chk("t5_cnt", int'(cnt0), 1);
    chk("t5_bin", int'(bin0), 88);
    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    cmt(0);
    settle();
    chk("t5_bin0", int'(bin0), 0);

    // Test 6: reset mid-entry, then the two-digit unit.
    dig(0, 4'd9); dig(0, 4'd9);
    step(0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    settle();
    chk("t6_acc", int'(acc0), 0);
    chk("t6_bin", int'(bin0), 0);
    chk("t6_rv", int'(rv0), 0);
    dig(1, 4'd9); dig(1, 4'd9);
    settle();
    chk("t6_full2", int'(full1), 1);
    dig(1, 4'd1);
    cmt(1);
    settle();
    chk("t6_bin99", int'(bin1), 99);

    // Randomized traffic on both units.
    for (int i = 0; i < 1500; i++) begin
      int u, p;
      logic [3:0] d;
      u = int'($urandom_range(0, 1));
      p = int'($urandom_range(0, 99));
      d = 4'($urandom_range(0, 15));
      if (p < 2)       step(u, 1'b1, 1'b1, d, 1'b0, 1'b0);
      else if (p < 7)  step(u, 1'b0, ($urandom_range(0, 1) == 1), d, 1'b1, 1'b1);
      else if (p < 17) step(u, 1'b0, ($urandom_range(0, 1) == 1), d, 1'b1, 1'b0);
      else if (p < 85) step(u, 1'b0, 1'b1, (p < 75) ? 4'($urandom_range(0, 9)) : d, 1'b0, 1'b0);
      else             step(u, 1'b0, 1'b0, d, 1'b0, 1'b0);
    end

    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("rq0_drained", rq0.size(), 0);
    chk("rq1_drained", rq1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
